// File: rtl/seq_detect_param_if.sv
// Serial detector port bundle: bitstream plus configuration in, match pulse and count out.
// Master drives stream/config; slave is the detector.
interface seq_detect_param_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    localparam int LW = $clog2(MAX_LEN + 1);

    logic               in;
    logic               in_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LW-1:0]      cfg_len;
    logic               cfg_overlap;
    logic               out;
    logic [CNT_W-1:0]   match_count;

    modport master (
        output in, in_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        input  out, match_count
    );

    modport slave (
        input  in, in_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        output out, match_count
    );
endinterface

// File: rtl/seq_detect_param.sv
// Runtime-programmable serial pattern detector with saturating match counter.
// Match pulse one cycle after the last bit; no backpressure, in_valid gaps hold all state.
module seq_detect_param #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(8'b0000_1011),
    parameter int                 RST_LEN     = 4,
    parameter bit                 RST_OVERLAP = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    seq_detect_param_if.slave bus
);
    localparam int            LW    = $clog2(MAX_LEN + 1);
    localparam logic [LW-1:0] MAX_L = LW'(MAX_LEN);
    localparam logic [LW-1:0] RST_L = (RST_LEN < 1)       ? LW'(1) :
                                      (RST_LEN > MAX_LEN) ? MAX_L  : LW'(RST_LEN);

    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [MAX_LEN-1:0] hist_q, hist_d, hist_sh, mask;
    logic [LW-1:0]      len_q, len_d;
    logic [LW-1:0]      fill_q, fill_d, fill_inc;
    logic [LW-1:0]      cfg_len_eff;
    logic               overlap_q, overlap_d;
    logic               out_q, out_d;
    logic               match;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern_q <= RST_PATTERN;
            len_q     <= RST_L;
            overlap_q <= RST_OVERLAP;
            hist_q    <= '0;
            fill_q    <= '0;
            out_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            out_q     <= out_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        // Stored length is always 1..MAX_LEN so the window compare never degenerates.
        cfg_len_eff = bus.cfg_len;
        if (bus.cfg_len == '0) begin
            cfg_len_eff = LW'(1);
        end else if (bus.cfg_len > MAX_L) begin
            cfg_len_eff = MAX_L;
        end

        hist_sh  = {hist_q[MAX_LEN-2:0], bus.in};
        fill_inc = (fill_q >= len_q) ? len_q : fill_q + 1'b1;

        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LW'(i) < len_q);
        end
        match = (fill_inc == len_q) && (((hist_sh ^ pattern_q) & mask) == '0);

        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        cnt_d     = cnt_q;
        out_d     = 1'b0;

        if (bus.cfg_load) begin
            pattern_d = bus.cfg_pattern;
            len_d     = cfg_len_eff;
            overlap_d = bus.cfg_overlap;
            hist_d    = '0;
            fill_d    = '0;
            cnt_d     = '0;
        end else if (bus.in_valid) begin
            hist_d = hist_sh;
            out_d  = match;
            // Non-overlap restarts the window so the next hit needs len fresh bits.
            fill_d = (match && !overlap_q) ? '0 : fill_inc;
            if (match && (cnt_q != '1)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign bus.out         = out_q;
    assign bus.match_count = cnt_q;
endmodule
